// File: rtl/wb_port_arb.sv
// Write-back port arbiter for the vcpu register file.
// Shares the single register-file write port between the in-order pipeline
// write-back and a small FIFO of late load returns. Pipeline writes win in
// NORMAL mode. A buffer that is full, or whose head has waited too long,
// switches to FORCE mode. FORCE stalls the pipeline until the buffer is empty.
// A pipeline write kills any queued load to the same register, because that
// load's data would otherwise overwrite the younger value.
module wb_port_arb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pipe_we,
  input  logic [4:0]                 pipe_waddr,
  input  logic [31:0]                pipe_wdata,
  output logic                       pipe_stall,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [4:0]                 ld_waddr,
  input  logic [31:0]                ld_wdata,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0] ld_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_MAX);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_FORCE  = 1'b1
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [DEPTH-1:0] occupied;
  logic [4:0]       waddr_q [DEPTH];
  logic [31:0]      wdata_q [DEPTH];

  logic grant_pipe;
  logic grant_head;
  logic push;
  logic pop;
  logic head_live;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake and stall come only from registered state, so neither
  // depends combinationally on the request inputs.
  assign pipe_stall = (mode_q == MODE_FORCE);
  assign ld_ready   = (count_q != FULL_CNT);
  assign ld_count   = count_q;

  assign push      = ld_valid && ld_ready;
  assign pop       = grant_head;
  assign head_live = !kill_q[head_q];

  // Choose the write-port owner for this cycle.
  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_pipe = 1'b0;
    grant_head = 1'b0;
    if (mode_q == MODE_NORMAL && pipe_we) begin
      grant_pipe = 1'b1;
    end else if (count_q != '0) begin
      grant_head = 1'b1;
    end
  end

  // Next occupancy and pointers after this cycle's push and pop.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
  end

  // Head waiting age. It restarts on every drain, and saturates so FORCE
  // entry stays a simple compare.
  always_comb begin
    age_d = age_q;
    if (pop || count_d == '0) begin
      age_d = '0;
    end else if (count_q != '0 && age_q != AGE_MAX) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  // Mode transitions use the post-update count and age.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_NORMAL: if (count_d == FULL_CNT || age_d == AGE_MAX) mode_d = MODE_FORCE;
      MODE_FORCE:  if (count_d == '0)                           mode_d = MODE_NORMAL;
      default:     mode_d = MODE_NORMAL;
    endcase
  end

  // Mark which buffer slots hold live entries, between head and tail.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == FULL_CNT) begin
        occupied[i] = 1'b1;
      end else if (head_q <= tail_q) begin
        occupied[i] = (PTR_W'(i) >= head_q) && (PTR_W'(i) < tail_q);
      end else begin
        occupied[i] = (PTR_W'(i) >= head_q) || (PTR_W'(i) < tail_q);
      end
    end
  end

  // An accepted pipeline write makes queued loads to the same register stale.
  // The head being popped now writes first, so it is left alone. A load pushed
  // in the same cycle is older than the pipe write and is killed on entry.
  always_comb begin
    kill_d = kill_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_pipe && occupied[i] && !(pop && PTR_W'(i) == head_q) &&
          waddr_q[i] == pipe_waddr) begin
        kill_d[i] = 1'b1;
      end
    end
    if (push) begin
      kill_d[tail_q] = grant_pipe && (ld_waddr == pipe_waddr);
    end
  end

  // Control state: mode, occupancy, pointers, age and kill flags.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values no matter what order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_NORMAL;
      count_q <= '0;
      age_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      kill_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      age_q   <= age_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      kill_q  <= kill_d;
    end
  end

  // Load payload storage, written on push.
  // NOTE: the payload array has no reset. Occupancy and kill flags decide
  // whether a slot is ever read, so its contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[tail_q] <= ld_waddr;
      wdata_q[tail_q] <= ld_wdata;
    end
  end

  // Registered write port. Address and data hold when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
      if (grant_pipe) begin
        rf_we    <= 1'b1;
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
      end else if (grant_head && head_live) begin
        rf_we    <= 1'b1;
        rf_waddr <= waddr_q[head_q];
        rf_wdata <= wdata_q[head_q];
      end
    end
  end

endmodule
